// File: rtl/issue_scoreboard_unit_pkg.sv
// issue_pkg: shared types and defaults for the issue/scoreboard stage.
//   - DefXlen / DefNregs / DefUopW : default data width, register count, uop width
//   - MaxXlen / MaxRaW / MaxUopW   : storage bounds of the output register struct;
//                                    instances must keep XLEN, RA_W and UOP_W within them
//   - bsel_e                       : op_b source select encoding (2'b11 aliases rs2)
//   - out_reg_t                    : output pipeline register contents

package issue_pkg;

  localparam int unsigned DefXlen  = 32;
  localparam int unsigned DefNregs = 32;
  localparam int unsigned DefUopW  = 32;

  // A package cannot be parameterised, so the struct is sized for the widest
  // supported instance. Narrower instances zero-extend into it, and synthesis
  // removes the constant upper bits.
  localparam int unsigned MaxXlen = 64;
  localparam int unsigned MaxRaW  = 8;
  localparam int unsigned MaxUopW = 64;

  typedef enum logic [1:0] {
    BSEL_RS2   = 2'b00,
    BSEL_IMM   = 2'b01,
    BSEL_SHAMT = 2'b10
  } bsel_e;

  typedef struct packed {
    logic               valid;
    logic               we;
    logic [MaxRaW-1:0]  rd;
    logic [MaxXlen-1:0] op_a;
    logic [MaxXlen-1:0] op_b;
    logic [MaxXlen-1:0] imm;
    logic [MaxXlen-1:0] pc;
    logic [MaxUopW-1:0] uop;
  } out_reg_t;

endpackage

// File: rtl/issue_scoreboard_unit_regfile.sv
// regfile_param: NREGS x XLEN architectural register file, two combinational read
// ports and one synchronous write port. Register 0 is never written and always
// reads as zero. Asynchronous active-low reset clears every register.
//   clk, nrst            clock, async active-low reset
//   rs1_addr, rs1_data   read port 1
//   rs2_addr, rs2_data   read port 2
//   we, waddr, wdata     write port (ignored when waddr is 0)

module regfile_param
  import issue_pkg::*;
#(
  parameter  int unsigned XLEN  = DefXlen,
  parameter  int unsigned NREGS = DefNregs,
  localparam int unsigned RA_W  = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic [RA_W-1:0] rs1_addr,
  output logic [XLEN-1:0] rs1_data,
  input  logic [RA_W-1:0] rs2_addr,
  output logic [XLEN-1:0] rs2_data,
  input  logic            we,
  input  logic [RA_W-1:0] waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] regs_q [NREGS];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rs1_data = (rs1_addr == '0) ? '0 : regs_q[rs1_addr];
  assign rs2_data = (rs2_addr == '0) ? '0 : regs_q[rs2_addr];

endmodule

// File: rtl/issue_scoreboard_unit.sv
// issue_scoreboard_unit: issue stage between decode and execute. Holds the register
// file and a per-register pending-write scoreboard, stalls on RAW/WAW hazards,
// resolves operands and registers them into a single output pipeline stage.
//
// Optional build macro ISSUE_WB_BYPASS_EN: a source whose pending write is being
// written back this cycle is not treated as a hazard and takes its data from wb_data.
// WAW checks and sb_pending are unaffected by the macro.
//
// Ports:
//   clk, nrst                        clock, async active-low reset
//   in_valid / in_ready              decode handshake
//   in_rs1, in_rs2, in_uses_rs1/2    source registers and read enables
//   in_rd, in_we                     destination and write enable
//   in_bsel, in_imm, in_pc, in_uop   op_b select, immediate, PC, control payload
//   out_valid / out_ready            execute handshake
//   out_op_a, out_op_b, out_imm,
//   out_pc, out_rd, out_we, out_uop  registered instruction to execute
//   wb_we, wb_rd, wb_data            writeback port
//   flush                            squash the instruction in the output register
//   sb_pending                       scoreboard pending bits

module issue_scoreboard_unit
  import issue_pkg::*;
#(
  parameter  int unsigned XLEN  = DefXlen,
  parameter  int unsigned NREGS = DefNregs,
  parameter  int unsigned UOP_W = DefUopW,
  localparam int unsigned RA_W  = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             nrst,

  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RA_W-1:0]  in_rs1,
  input  logic [RA_W-1:0]  in_rs2,
  input  logic             in_uses_rs1,
  input  logic             in_uses_rs2,
  input  logic [RA_W-1:0]  in_rd,
  input  logic             in_we,
  input  logic [1:0]       in_bsel,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [UOP_W-1:0] in_uop,

  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_op_a,
  output logic [XLEN-1:0]  out_op_b,
  output logic [XLEN-1:0]  out_imm,
  output logic [XLEN-1:0]  out_pc,
  output logic [RA_W-1:0]  out_rd,
  output logic             out_we,
  output logic [UOP_W-1:0] out_uop,

  input  logic             wb_we,
  input  logic [RA_W-1:0]  wb_rd,
  input  logic [XLEN-1:0]  wb_data,

  input  logic             flush,
  output logic [NREGS-1:0] sb_pending
);

  logic [NREGS-1:0] pend_q, pend_d;
  out_reg_t         out_q, out_d;

  logic [XLEN-1:0]  rf_rs1, rf_rs2;
  logic [XLEN-1:0]  rs1_data, rs2_data;
  logic             rs1_busy, rs2_busy;
  logic             hazard, fire;
  logic [XLEN-1:0]  op_a, op_b;

  regfile_param #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk      (clk),
    .nrst     (nrst),
    .rs1_addr (in_rs1),
    .rs1_data (rf_rs1),
    .rs2_addr (in_rs2),
    .rs2_data (rf_rs2),
    .we       (wb_we),
    .waddr    (wb_rd),
    .wdata    (wb_data)
  );

  // Source readiness and data. The bypass only forwards to source reads.
`ifdef ISSUE_WB_BYPASS_EN
  logic byp_rs1, byp_rs2;

  assign byp_rs1  = wb_we && (wb_rd == in_rs1) && (in_rs1 != '0);
  assign byp_rs2  = wb_we && (wb_rd == in_rs2) && (in_rs2 != '0);
  assign rs1_busy = pend_q[in_rs1] && !byp_rs1;
  assign rs2_busy = pend_q[in_rs2] && !byp_rs2;
  assign rs1_data = byp_rs1 ? wb_data : rf_rs1;
  assign rs2_data = byp_rs2 ? wb_data : rf_rs2;
`else
  assign rs1_busy = pend_q[in_rs1];
  assign rs2_busy = pend_q[in_rs2];
  assign rs1_data = rf_rs1;
  assign rs2_data = rf_rs2;
`endif

  assign hazard = (in_uses_rs1 && rs1_busy) ||
                  (in_uses_rs2 && rs2_busy) ||
                  (in_we && (in_rd != '0) && pend_q[in_rd]);

  // nrst gates in_ready so decode sees no acceptance while reset is held.
  assign in_ready = nrst && (!out_q.valid || out_ready) && !hazard && !flush;
  assign fire     = in_valid && in_ready;

  assign op_a = in_uses_rs1 ? rs1_data : '0;

  always_comb begin
    op_b = rs2_data;
    case (bsel_e'(in_bsel))
      BSEL_IMM:   op_b = in_imm;
      BSEL_SHAMT: op_b = {{(XLEN-5){1'b0}}, in_imm[4:0]};
      default:    op_b = rs2_data;
    endcase
  end

  // Output register: flush kills, fire loads, a taken handoff without refill
  // empties, otherwise every field holds (back-pressure).
  always_comb begin
    out_d = out_q;
    if (flush) begin
      out_d.valid = 1'b0;
    end else if (fire) begin
      out_d.valid = 1'b1;
      out_d.we    = in_we;
      out_d.rd    = MaxRaW'(in_rd);
      out_d.op_a  = MaxXlen'(op_a);
      out_d.op_b  = MaxXlen'(op_b);
      out_d.imm   = MaxXlen'(in_imm);
      out_d.pc    = MaxXlen'(in_pc);
      out_d.uop   = MaxUopW'(in_uop);
    end else if (out_ready) begin
      out_d.valid = 1'b0;
    end
  end

  // Clears are applied before the set so a new writer keeps ownership of an
  // index that is written back in the same cycle.
  always_comb begin
    pend_d = pend_q;
    if (wb_we) begin
      pend_d[wb_rd] = 1'b0;
    end
    if (flush && out_q.valid && out_q.we) begin
      pend_d[out_q.rd[RA_W-1:0]] = 1'b0;
    end
    if (fire && in_we) begin
      pend_d[in_rd] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      out_q  <= '0;
      pend_q <= '0;
    end else begin
      out_q  <= out_d;
      pend_q <= pend_d;
    end
  end

  assign out_valid  = out_q.valid && !flush;
  assign out_we     = out_q.we;
  assign out_rd     = out_q.rd[RA_W-1:0];
  assign out_op_a   = out_q.op_a[XLEN-1:0];
  assign out_op_b   = out_q.op_b[XLEN-1:0];
  assign out_imm    = out_q.imm[XLEN-1:0];
  assign out_pc     = out_q.pc[XLEN-1:0];
  assign out_uop    = out_q.uop[UOP_W-1:0];
  assign sb_pending = pend_q;

  // Upper struct bits beyond the instance widths are constant zero.
  logic unused_out_q;
  assign unused_out_q = ^out_q;

endmodule

// File: doc/issue_scoreboard_unit.md
Name: issue_scoreboard_unit

Overview:
Parametrised successor to the current issue stage. It sits between decode and execute and holds the architectural register file and a per-register pending-write scoreboard. Instructions are accepted on a valid/ready handshake, stalled on RAW/WAW hazards, and have operands resolved into a single output pipeline register. Width, register count and control payload are generalised; flush recovers squashed scoreboard state.

Parameters:
XLEN, 32, data/PC width
NREGS, 32, architectural registers; index 0 hardwired to zero
UOP_W, 32, opaque decoded-control payload width, passed through unchanged
RA_W, $clog2(NREGS), register-address width (localparam, derived)

Ports:
clk  in  1  clock
nrst  in  1  reset, asynchronous, active-low
in_valid  in  1  decode presents an instruction
in_ready  out  1  issue accepts this cycle
in_rs1, in_rs2  in  RA_W  source register addresses
in_uses_rs1, in_uses_rs2  in  1  source is actually read
in_rd  in  RA_W  destination register
in_we  in  1  instruction writes in_rd
in_bsel  in  2  op_b select: 00 rs2, 01 imm, 10 {0, imm[4:0]}, 11 rs2
in_imm, in_pc  in  XLEN  immediate, PC
in_uop  in  UOP_W  control payload
out_valid  out  1  execute-side instruction valid
out_ready  in  1  execute accepts
out_op_a, out_op_b, out_imm, out_pc  out  XLEN  resolved operands, immediate and PC
out_rd  out  RA_W  destination register
out_we  out  1  write enable
out_uop  out  UOP_W  control payload
wb_we  in  1  writeback valid
wb_rd  in  RA_W  writeback address
wb_data  in  XLEN  writeback data
flush  in  1  squash the instruction in the output register
sb_pending  out  NREGS  scoreboard bit-vector (debug/perf)

Behaviour:
- Reset (nrst low, async):
  - out_valid=0; all out_* =0.
  - Scoreboard cleared; register file cleared.
  - in_ready=0 during reset.
- Register file:
  - Written at posedge when wb_we && wb_rd!=0.
  - Reads are combinational.
  - Register 0 reads 0 at all times.
- hazard = (in_uses_rs1 && pend[in_rs1]) || (in_uses_rs2 && pend[in_rs2]) || (in_we && in_rd!=0 && pend[in_rd]).
  - pend[0] is always 0.
- in_ready = (!out_valid_q || out_ready) && !hazard && !flush.
- Issue fire = in_valid && in_ready. On fire, at the next posedge:
  - out register is loaded.
  - out_op_a = in_uses_rs1 ? rf[rs1] : 0.
  - out_op_b is selected per in_bsel.
  - pend[in_rd] is set if in_we && in_rd!=0.
- Latency: one cycle from fire to out_valid.
- Back-pressure: if out_valid_q && !out_ready, the out register holds all fields unchanged.
- Accept without refill: if out_valid_q && out_ready && no fire, then out_valid_q clears.
- Writeback: wb_we clears pend[wb_rd] at posedge.
  - Same-cycle set and clear of the same index: set wins (new writer owns it).
- Flush:
  - out_valid = out_valid_q && !flush (combinational mask); execute ignores the handshake during flush.
  - At posedge, out_valid_q clears.
  - If the killed entry had out_we && out_rd!=0, its pend bit is cleared, unless a new fire sets the same index in that cycle (impossible, since in_ready=0).
  - Older instructions already in execute still write back normally.
- Flush and writeback to the same index in the same cycle: both clear the bit, giving a consistent 0.
- Back-to-back dependents without bypass:
  - A dependent stalls until the cycle after wb_we.
  - It then reads the freshly written register file.
  - Minimum RAW bubble is the writeback distance plus one cycle.

Optional Feature:
- Macro ISSUE_WB_BYPASS_EN.
- When defined:
  - The hazard term for a source ignores pend[x] when wb_we && wb_rd==x && x!=0.
  - Operand data is muxed from wb_data in that cycle.
  - WAW hazards are still evaluated against pend without bypass.
- When undefined: no bypass mux and stalls as above.
- sb_pending behaviour is identical in both builds.

Decomposition:
- Package issue_pkg holds:
  - the bsel encoding enum (BSEL_RS2, BSEL_IMM, BSEL_SHAMT);
  - XLEN and NREGS defaults;
  - the output pipeline-register struct typedef.
- One sub-module: regfile_param (NREGS x XLEN, 2R1W, x0 zero). The scoreboard and hazard logic stay inline.

Test Plan:
- Reset mid-traffic: pulse nrst low with out_valid=1 and pend[5]=1 -> out_valid=0, sb_pending=0, and x5 reads 0 immediately.
- RAW stall: issue rd=3 we=1, then in_rs1=3 uses_rs1=1 -> in_ready=0 until wb_we rd=3 data=0xDEAD.
  - Without bypass: fires the next cycle with out_op_a=0xDEAD.
  - With ISSUE_WB_BYPASS_EN: fires in the wb cycle with out_op_a=0xDEAD.
- Back-pressure: hold out_ready=0 for 4 cycles with in_valid=1 -> in_ready=0 and out_* stable; release -> exactly one handoff, no duplicate or loss.
- Flush: issue rd=7 we=1, then assert flush while out_valid_q=1 -> out_valid=0 that cycle, pend[7]=0 next cycle, and in_ready=0 during flush.
- Same-cycle set/clear: wb_we rd=9 while firing an instruction with rd=9 -> pend[9]=1 afterward; x9 holds the wb data.
- x0 and bsel: write wb_rd=0 data=0xFFFF -> x0 still reads 0.
  - bsel=10 with imm=0xFFFFFFE3 -> out_op_b=0x3.
  - bsel=01 -> out_op_b=0xFFFFFFE3.
